// File: rtl/tqvp_reg_arbiter.sv
// Two-port round-robin arbiter that serializes register accesses onto a TinyQV peripheral bus.
// Latency: ack WAIT_CYCLES+2 cycles after the grant edge; requests are only sampled in IDLE, losers simply wait.
module tqvp_reg_arbiter #(
    parameter int ADDR_W      = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        wdata0,
    input  logic [7:0]        wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [7:0]        rdata0,
    output logic [7:0]        rdata1,
    output logic [ADDR_W-1:0] periph_address,
    output logic [7:0]        periph_data_in,
    output logic              periph_data_write,
    input  logic [7:0]        periph_data_out,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_wait;
    logic        r_we;
    logic        r_owner;
    logic        r_last;

    logic              w_grant_vld;
    logic              w_grant_idx;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_wdata;
    logic              w_finish;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_vld) w_next = S_ACCESS;
            S_ACCESS: if (r_wait == 4'd0) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // On a tie, the requester that did not win last time gets the bus.
    always_comb begin
        w_grant_vld = req0 | req1;
        w_grant_idx = (req0 & req1) ? ~r_last : req1;
        w_sel_we    = w_grant_idx ? we1    : we0;
        w_sel_addr  = w_grant_idx ? addr1  : addr0;
        w_sel_wdata = w_grant_idx ? wdata1 : wdata0;
        w_finish    = (r_state == S_ACCESS) && (r_wait == 4'd0);
        busy        = (r_state != S_IDLE);
        owner       = r_owner;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait            <= 4'd0;
            r_we              <= 1'b0;
            r_owner           <= 1'b0;
            r_last            <= 1'b1;
            ack0              <= 1'b0;
            ack1              <= 1'b0;
            rdata0            <= 8'h00;
            rdata1            <= 8'h00;
            periph_address    <= '0;
            periph_data_in    <= 8'h00;
            periph_data_write <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_owner           <= w_grant_idx;
                        r_we              <= w_sel_we;
                        r_wait            <= WAIT_INIT;
                        periph_address    <= w_sel_addr;
                        periph_data_in    <= w_sel_we ? w_sel_wdata : 8'h00;
                        periph_data_write <= w_sel_we;
                    end
                end
                S_ACCESS: begin
                    periph_data_write <= 1'b0;
                    if (!w_finish) begin
                        r_wait <= r_wait - 4'd1;
                    end else begin
                        if (!r_we) begin
                            if (r_owner) rdata1 <= periph_data_out;
                            else         rdata0 <= periph_data_out;
                        end
                        if (r_owner) ack1 <= 1'b1;
                        else         ack0 <= 1'b1;
                        r_last         <= r_owner;
                        periph_address <= '0;
                        periph_data_in <= 8'h00;
                    end
                end
                S_DONE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                end
                default: begin
                    ack0              <= 1'b0;
                    ack1              <= 1'b0;
                    periph_data_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// Directed bench for tqvp_reg_arbiter: a WAIT_CYCLES=1 instance for the main tests and a WAIT_CYCLES=0 instance.
module tb_tqvp_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic [3:0] pa;
    logic [7:0] pdi;
    logic       pdw;
    logic [7:0] pdo;
    logic       busy, owner;

    logic       z_req, z_ack, z_ack1, z_pdw, z_busy, z_owner;
    logic [3:0] z_addr, z_pa;
    logic [7:0] z_rdata, z_rdata1, z_pdi, z_pdo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] model_rd(input logic [3:0] a);
        logic [7:0] d;
        d = {a, ~a};
        if (a == 4'h3) d = 8'hA5;
        return d;
    endfunction

    assign pdo   = model_rd(pa);
    assign z_pdo = model_rd(z_pa);

    tqvp_reg_arbiter #(.ADDR_W(4), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .periph_address(pa), .periph_data_in(pdi), .periph_data_write(pdw),
        .periph_data_out(pdo), .busy(busy), .owner(owner)
    );

    tqvp_reg_arbiter #(.ADDR_W(4), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .req0(z_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(z_addr), .addr1(4'h0), .wdata0(8'h00), .wdata1(8'h00),
        .ack0(z_ack), .ack1(z_ack1), .rdata0(z_rdata), .rdata1(z_rdata1),
        .periph_address(z_pa), .periph_data_in(z_pdi), .periph_data_write(z_pdw),
        .periph_data_out(z_pdo), .busy(z_busy), .owner(z_owner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Counts negedges from the driving negedge until ack on the given port.
    task automatic wait_ack(input int port, input int maxc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(port != 0 ? ack1 : ack0) && cyc < maxc);
        if (!(port != 0 ? ack1 : ack0)) chk("ack_timeout", 32'(cyc), 32'(maxc + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, nw, nack, n, expo, port, lastc, cnt0, cnt1;

        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'h8; addr1 = 4'h5; wdata0 = 8'h00; wdata1 = 8'h00;
        z_req = 1'b0; z_addr = 4'h0;

        // Reset held with both requests pending.
        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_ack0", ack0, 0);
            chk("rst_ack1", ack1, 0);
            chk("rst_rdata0", rdata0, 0);
            chk("rst_rdata1", rdata1, 0);
            chk("rst_pa", pa, 0);
            chk("rst_pdi", pdi, 0);
            chk("rst_pdw", pdw, 0);
            chk("rst_owner", owner, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_owner", owner, 0);
        chk("first_busy", busy, 1);
        chk("first_pa", pa, 4'h8);
        req1 = 1'b0;
        wait_ack(0, 10, c);
        chk("first_ack_cyc", c, 2);
        chk("first_rdata0", rdata0, 8'h87);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        // Single read of address 3.
        req0 = 1'b1; addr0 = 4'h3;
        @(negedge clk);
        chk("rd_pa_c1", pa, 4'h3);
        chk("rd_pdw", pdw, 0);
        @(negedge clk);
        chk("rd_pa_c2", pa, 4'h3);
        chk("rd_ack_early", ack0, 0);
        @(negedge clk);
        chk("rd_ack0", ack0, 1);
        chk("rd_rdata0", rdata0, 8'hA5);
        chk("rd_ack1", ack1, 0);
        req0 = 1'b0;
        @(negedge clk);
        chk("rd_ack0_clr", ack0, 0);
        chk("rd_pa_idle", pa, 0);
        chk("rd_rdata0_hold", rdata0, 8'hA5);
        @(negedge clk);
        chk("rd_busy_idle", busy, 0);

        // Write from requester 1.
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'hC; wdata1 = 8'h5A;
        nw = 0; nack = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (pdw) begin
                nw++;
                chk("wr_pdw_cyc", i, 1);
                chk("wr_pa", pa, 4'hC);
                chk("wr_pdi", pdi, 8'h5A);
            end
            if (ack1) begin
                nack++;
                chk("wr_ack_cyc", i, 3);
                req1 = 1'b0;
            end
            chk("wr_no_ack0", ack0, 0);
        end
        chk("wr_pdw_count", nw, 1);
        chk("wr_ack_count", nack, 1);
        chk("wr_rdata1", rdata1, 0);
        chk("wr_pdi_idle", pdi, 0);
        we1 = 1'b0;

        // Contention: both requesters reading continuously.
        addr0 = 4'h4; addr1 = 4'h9;
        req0 = 1'b1; req1 = 1'b1;
        n = 0; expo = 0; c = 0; lastc = 0; cnt0 = 0; cnt1 = 0;
        while (n < 12 && c < 100) begin
            @(negedge clk);
            c++;
            if (pdw) chk("ct_pdw", pdw, 0);
            if (ack0 || ack1) begin
                port = ack1 ? 1 : 0;
                chk("ct_ack_both", ack0 & ack1, 0);
                chk("ct_order", port, expo);
                chk("ct_rdata", port != 0 ? rdata1 : rdata0, model_rd(port != 0 ? 4'h9 : 4'h4));
                if (n > 0) chk("ct_period", c - lastc, 4);
                lastc = c;
                if (port != 0) cnt1++; else cnt0++;
                expo = 1 - expo;
                n++;
                if (n == 12) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
            end
        end
        chk("ct_total", n, 12);
        chk("ct_cnt0", cnt0, 6);
        chk("ct_cnt1", cnt1, 6);
        repeat (2) @(negedge clk);

        // Reset during the second ACCESS cycle of a read.
        req0 = 1'b1; addr0 = 4'h7;
        @(negedge clk);
        @(negedge clk);
        chk("ab_pre_ack", ack0, 0);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk("ab_ack0", ack0, 0);
        chk("ab_rdata0", rdata0, 0);
        chk("ab_busy", busy, 0);
        chk("ab_pdw", pdw, 0);
        chk("ab_pa", pa, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("ab_noack", ack0, 0);
        end
        req0 = 1'b1; addr0 = 4'h3;
        wait_ack(0, 10, c);
        chk("ab_next_cyc", c, 3);
        chk("ab_next_rdata", rdata0, 8'hA5);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        // WAIT_CYCLES=0 instance: 2-cycle ack, 3-cycle period.
        z_req = 1'b1; z_addr = 4'h6;
        @(negedge clk);
        chk("w0_pa", z_pa, 4'h6);
        chk("w0_ack_early", z_ack, 0);
        @(negedge clk);
        chk("w0_ack", z_ack, 1);
        chk("w0_rdata", z_rdata, 8'h69);
        repeat (2) begin
            @(negedge clk);
            chk("w0_gap", z_ack, 0);
        end
        @(negedge clk);
        chk("w0_ack2", z_ack, 1);
        chk("w0_rdata2", z_rdata, 8'h69);
        chk("w0_ack1", z_ack1, 0);
        z_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tqvp_reg_arbiter.md
# tqvp_reg_arbiter

Two-port round-robin arbiter and access sequencer for a TinyQV peripheral register bus (address / data_in / data_write / data_out). It lets two requesters share one peripheral, for example the SPI register bridge and an on-chip polling engine that drains TRNG output words. Each transaction is serialized into a fixed-length bus access with a programmable read-settle delay, and is acknowledged to its owner with a one-cycle pulse.

## Interface
- ADDR_W, 4: register address width.
- WAIT_CYCLES, 1: extra ACCESS cycles before read data is captured. Legal range is 0..15.

- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req0 / req1  in  1  access request from requester 0 / 1.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  register address.
- wdata0 / wdata1  in  8  write data.
- ack0 / ack1  out  1  one-cycle completion pulse, registered.
- rdata0 / rdata1  out  8  read result, registered; valid when ack is high, then held.
- periph_address  out  ADDR_W  peripheral register address, registered.
- periph_data_in  out  8  peripheral write data, registered.
- periph_data_write  out  1  peripheral write strobe, registered, high for exactly 1 cycle per write.
- periph_data_out  in  8  peripheral read data, combinational from periph_address.
- busy  out  1  high in any state except IDLE.
- owner  out  1  index of the current or most recent grantee.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req0/req1 are sampled only in IDLE.
  - If exactly one is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - On grant: latch we/addr/wdata of the winner, set owner, and load wait_cnt=WAIT_CYCLES.
  - On the same edge: periph_address<=addr; periph_data_in<=we?wdata:0; periph_data_write<=we; go to ACCESS.
- ACCESS:
  - periph_data_write clears after the first ACCESS cycle.
  - While wait_cnt≠0, decrement it and stay in ACCESS.
  - When wait_cnt==0:
    - For a read, rdata[owner]<=periph_data_out.
    - Set ack[owner]<=1, last_grant<=owner, clear periph_address to 0, and go to DONE.
- DONE: ack clears on the next edge; go to IDLE.
- Write transactions leave rdata unchanged.
- Requester contract:
  - Hold req, we, addr and wdata stable from assertion until the ack cycle.
  - If req is still high in the cycle after ack, it is treated as a new request.
- Idle bus values: periph_address=0, periph_data_in=0, periph_data_write=0.
- Reset values:
  - State IDLE; last_grant=1, so requester 0 wins the first tie.
  - owner=0, busy=0, ack0=ack1=0, rdata0=rdata1=0.
  - All periph_* outputs 0.
- Reset mid-transaction: abort on the reset edge. No ack is issued, rdata keeps its reset value of 0, and periph_data_write is 0 from the following cycle.
- A request that drops before being granted is ignored. A request that drops while in ACCESS is a contract violation: the access still completes and is still acked.

## Timing
- Sampling edge E0 occurs in IDLE with req high.
- periph_address and periph_data_write are valid in cycle E0+1.
- ACCESS spans WAIT_CYCLES+1 cycles.
- rdata is captured at the end of ACCESS. ack is high in cycle E0+WAIT_CYCLES+2.
- Per-access period is WAIT_CYCLES+3 cycles, because the FSM returns to IDLE for one cycle between accesses.
- Under continuous dual requests, grants strictly alternate 0,1,0,1…
- A single continuous requester gets back-to-back accesses at the full period rate.
- periph_data_write is never high for more than one cycle, and never high outside ACCESS.

## Test plan
- **Reset:** hold rst 3 cycles with req0=req1=1 → all outputs 0 and busy=0 during reset. The first grant after release goes to requester 0.
- **Single read, WAIT_CYCLES=1:**
  - Stimulus: peripheral model returns 0xA5 at address 0x3; req0 read addr 0x3.
  - Response: periph_address=0x3 for 2 cycles; ack0 high 3 cycles after the sampling edge; rdata0=0xA5; ack1 never asserts.
- **Write:**
  - Stimulus: req1 write addr 0xC, wdata 0x5A.
  - Response: periph_data_write high exactly 1 cycle, with periph_address=0xC and periph_data_in=0x5A in that cycle; ack1 pulses; rdata1 unchanged.
- **Contention:**
  - Stimulus: req0 and req1 both held high for 12 accesses, with reads to different addresses.
  - Response: grants alternate 0,1,0,… with 6 acks on each port; each rdata matches its own address.
- **Abort:**
  - Stimulus: assert rst in the second ACCESS cycle of a read, then release.
  - Response: no ack; rdata0=0; FSM in IDLE; a subsequent request completes normally.
- **WAIT_CYCLES=0 build:** a read acks 2 cycles after the sampling edge with correct data, and the period is 3 cycles under a continuous request.
